tri_bus_arbiter: RTL and testbench

//  Shares one bidirectional (tristate) pad bus between NREQ requesters using single-beat drive/sample transfers.

---
 rtl/tri_bus_pkg.sv | 26 ++
 rtl/tri_bus_if.sv | 20 ++
 rtl/tri_bus_pad.sv | 12 +
 rtl/tri_bus_arbiter.sv | 103 ++++++++++
 tb/tb_tri_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tristate pad-bus arbiter: FSM states,
// direction encoding and the round-robin search.
package tri_bus_pkg;
  typedef enum logic [1:0] {IDLE, TURN, XFER} state_e;

  localparam logic DIR_DRIVE  = 1'b1;
  localparam logic DIR_SAMPLE = 1'b0;

  localparam int RR_MAX = 32;
  localparam int RR_IW  = 5;

  // First set request strictly after ptr, wrapping mod n; returns ptr if none.
  // Scanning from the far end lets the nearest candidate win the last write.
  function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int ptr, input int n);
    int p;
    int cand;
    p = ptr;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        cand = (ptr + k) % n;
        if (req[cand[RR_IW-1:0]]) p = cand;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/tri_bus_if.sv
// Requester/pad-side bundle of the tristate bus arbiter.
interface tri_bus_if #(
  parameter int WIDTH = 2,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       we;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rdata;
  logic                  busy;
  logic [WIDTH-1:0]      io_out;
  logic                  io_oe;
  logic [WIDTH-1:0]      io_in;

  modport master (output req, we, wdata, io_in,
                  input  ack, rdata, busy, io_out, io_oe);
  modport slave  (input  req, we, wdata, io_in,
                  output ack, rdata, busy, io_out, io_oe);
endinterface

// File: rtl/tri_bus_pad.sv
// Tristate pad driver; lives in the parent so the arbiter itself has no inout.
module tri_bus_pad #(
  parameter int WIDTH = 2
) (
  inout  wire  [WIDTH-1:0] io,
  input  logic [WIDTH-1:0] out,
  input  logic             oe,
  output logic [WIDTH-1:0] in
);
  assign io = oe ? out : {WIDTH{1'bz}};
  assign in = io;
endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter sharing one tristate pad bus, with turnaround dead cycles
// on direction change. Define TRI_BUS_PARK_EN to keep the bus driven after writes.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int NREQ     = 2,
  parameter int TURN_CYC = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  tri_bus_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_e                     state, state_nx;
  logic [IW-1:0]              rr_ptr, idx_q, idx_nx, pick;
  logic                       dir_q, dir_nx, last_dir;
  logic [WIDTH-1:0]           wd_q, wd_nx, out_nx;
  logic [CW-1:0]              cnt, cnt_nx;
  logic                       oe_nx;
  logic [NREQ-1:0]            ack_nx;
  logic [NREQ-1:0][WIDTH-1:0] wd_lane;

  assign wd_lane = bus.wdata;
  assign pick    = IW'(rr_pick(RR_MAX'(bus.req), 32'(rr_ptr), NREQ));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    dir_nx   = dir_q;
    wd_nx    = wd_q;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (bus.ack == '0 && |bus.req) begin
        idx_nx = pick;
        dir_nx = bus.we[pick];
        wd_nx  = wd_lane[pick];
        if (TURN_CYC > 0 && dir_nx != last_dir) begin
          state_nx = TURN;
          cnt_nx   = CNT_INIT;
        end else begin
          state_nx = XFER;
        end
      end
      TURN: if (cnt == '0) state_nx = XFER;
            else           cnt_nx   = cnt - CW'(1);
      XFER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Pad controls are decided from the next state so they are registered.
`ifdef TRI_BUS_PARK_EN
    oe_nx = bus.io_oe;
`else
    oe_nx = 1'b0;
`endif
    out_nx = bus.io_out;
    if (state_nx == TURN) oe_nx = 1'b0;
    if (state_nx == XFER && state != XFER) begin
      oe_nx = dir_nx;
      if (dir_nx == DIR_DRIVE) out_nx = wd_nx;
    end

    ack_nx = '0;
    if (state == XFER) ack_nx[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr     <= IW'(NREQ - 1);
      idx_q      <= '0;
      dir_q      <= DIR_SAMPLE;
      wd_q       <= '0;
      cnt        <= '0;
      last_dir   <= DIR_SAMPLE;
      bus.io_oe  <= 1'b0;
      bus.io_out <= '0;
      bus.ack    <= '0;
      bus.rdata  <= '0;
      bus.busy   <= 1'b0;
    end else begin
      idx_q      <= idx_nx;
      dir_q      <= dir_nx;
      wd_q       <= wd_nx;
      cnt        <= cnt_nx;
      if (state == IDLE && state_nx != IDLE) rr_ptr <= idx_nx;
      if (state == XFER) begin
        last_dir <= dir_q;
        if (dir_q == DIR_SAMPLE) bus.rdata <= bus.io_in;
      end
      bus.io_oe  <= oe_nx;
      bus.io_out <= out_nx;
      bus.ack    <= ack_nx;
      bus.busy   <= (state_nx != IDLE);
    end
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-timing reference model.
module tb_tri_bus_arbiter;
  localparam int W  = 2;
  localparam int N  = 2;
  localparam int TC = 1;
  localparam int NC = 1500;
`ifdef TRI_BUS_PARK_EN
  localparam logic PARK = 1'b1;
`else
  localparam logic PARK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tri_bus_if #(.WIDTH(W), .NREQ(N)) b();
  tri_bus_if #(.WIDTH(W), .NREQ(N)) b2();

  logic [W-1:0] ext1 = '0;
  wire  [W-1:0] io_w;
  wire  [W-1:0] pad_in;

  // External device drives the pad whenever the arbiter releases it.
  assign io_w    = b.io_oe ? {W{1'bz}} : ext1;
  assign b.io_in = pad_in;

  tri_bus_pad #(.WIDTH(W)) u_pad (.io(io_w), .out(b.io_out), .oe(b.io_oe), .in(pad_in));

  tri_bus_arbiter #(.WIDTH(W), .NREQ(N), .TURN_CYC(TC)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  tri_bus_arbiter #(.WIDTH(W), .NREQ(N), .TURN_CYC(0))  dut0 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] wdata;
    logic [W-1:0]   ext;
    int             lat;
    logic [N-1:0]   ack;
    logic [W-1:0]   rd;
    logic           drv;
    logic [W-1:0]   out;
  } vec_t;

  vec_t tbl [7];

  logic [N-1:0] ev_ack   [NC+8];
  logic         ev_busy  [NC+8];
  logic         ev_oe_v  [NC+8];
  logic         ev_oe    [NC+8];
  logic [W-1:0] ev_out   [NC+8];
  logic         ev_rd_v  [NC+8];
  int           ev_rd_src[NC+8];
  logic [W-1:0] ext_hist [NC+8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_inputs();
    b.req = '0;  b.we = '0;  b.wdata = '0;
    b2.req = '0; b2.we = '0; b2.wdata = '0; b2.io_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           idx, turn, x, t0, got;
    int           m_ptr, m_free;
    logic         m_dir, m_oe;
    logic [W-1:0] m_out, m_rd;
    logic [N-1:0] aseq [4];
    int           at [4];

    tbl[0] = '{2'b01, 2'b00, 4'b0000, 2'b10, 2, 2'b01, 2'b10, 1'b0, 2'b00};
    tbl[1] = '{2'b10, 2'b10, 4'b0100, 2'b00, 3, 2'b10, 2'b10, 1'b1, 2'b01};
    tbl[2] = '{2'b01, 2'b01, 4'b0011, 2'b00, 2, 2'b01, 2'b10, 1'b1, 2'b11};
    tbl[3] = '{2'b10, 2'b00, 4'b0000, 2'b01, 3, 2'b10, 2'b01, 1'b0, 2'b00};
    tbl[4] = '{2'b11, 2'b00, 4'b0000, 2'b11, 2, 2'b01, 2'b11, 1'b0, 2'b00};
    tbl[5] = '{2'b11, 2'b11, 4'b1001, 2'b00, 3, 2'b10, 2'b11, 1'b1, 2'b10};
    tbl[6] = '{2'b01, 2'b01, 4'b1000, 2'b00, 2, 2'b01, 2'b11, 1'b1, 2'b00};

    clr_inputs();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_oe",     32'(b.io_oe),  32'd0);
    chk("rst_out",    32'(b.io_out), 32'd0);
    chk("rst_ack",    32'(b.ack),    32'd0);
    chk("rst_rdata",  32'(b.rdata),  32'd0);
    chk("rst_busy",   32'(b.busy),   32'd0);
    chk("rst_oe_tc0", 32'(b2.io_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single transfers: latency, direction changes, rr order, data.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      b.req = tbl[v].req; b.we = tbl[v].we; b.wdata = tbl[v].wdata; ext1 = tbl[v].ext;
      for (int k = 1; k <= tbl[v].lat; k++) begin
        @(negedge clk);
        if (k == tbl[v].lat) begin
          chk("vec_ack",   32'(b.ack),   32'(tbl[v].ack));
          chk("vec_rdata", 32'(b.rdata), 32'(tbl[v].rd));
          b.req = '0;
        end else begin
          chk("vec_ack_early", 32'(b.ack), 32'd0);
        end
        if (k == tbl[v].lat - 1) begin
          chk("vec_xfer_oe", 32'(b.io_oe), 32'(tbl[v].drv));
          if (tbl[v].drv) chk("vec_xfer_out", 32'(b.io_out), 32'(tbl[v].out));
        end else if (k == 1) begin
          chk("vec_turn_oe", 32'(b.io_oe), 32'd0);
        end
      end
    end

    // Reset while in TURN drops the transfer.
    @(negedge clk);
    b.req = 2'b01; b.we = 2'b00; ext1 = 2'b01;
    @(negedge clk);
    chk("rstmid_busy_pre", 32'(b.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_oe",   32'(b.io_oe), 32'd0);
    chk("rstmid_busy", 32'(b.busy),  32'd0);
    chk("rstmid_ack",  32'(b.ack),   32'd0);
    b.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rstmid_no_ack",  32'(b.ack),  32'd0);
      chk("rstmid_no_busy", 32'(b.busy), 32'd0);
    end

    // Write 11 then idle: bus parked or released depending on build.
    @(negedge clk);
    b.req = 2'b01; b.we = 2'b01; b.wdata = 4'b0011;
    @(negedge clk);
    chk("park_turn_oe", 32'(b.io_oe), 32'd0);
    @(negedge clk);
    chk("park_xfer_oe",  32'(b.io_oe),  32'd1);
    chk("park_xfer_out", 32'(b.io_out), 32'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("park_ack", 32'(b.ack), 32'd1);
        b.req = '0;
      end
      chk("park_idle_oe", 32'(b.io_oe), 32'(PARK));
      if (b.io_oe) chk("park_idle_out", 32'(b.io_out), 32'd3);
    end

    // Two sampling requesters held together: strict alternation, 3-cycle spacing.
    do_reset();
    @(negedge clk);
    b.req = 2'b11; b.we = 2'b00; ext1 = 2'b10;
    t0 = cyc; got = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (b.ack != '0 && got < 4) begin
        aseq[got] = b.ack; at[got] = cyc; got++;
      end
    end
    b.req = '0;
    chk("cont_count", 32'(got), 32'd4);
    chk("cont_first_lat", 32'(at[0] - t0), 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("cont_order", 32'(aseq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk("cont_spacing", 32'(at[k] - at[k-1]), 32'd3);
    end

    // Randomized traffic vs. transaction-timing model.
    do_reset();
    for (int c = 0; c < NC + 8; c++) begin
      ev_ack[c] = '0; ev_busy[c] = 1'b0; ev_oe_v[c] = 1'b0; ev_oe[c] = 1'b0;
      ev_out[c] = '0; ev_rd_v[c] = 1'b0; ev_rd_src[c] = 0; ext_hist[c] = '0;
    end
    m_ptr = N - 1; m_free = 0; m_dir = 1'b0; m_oe = 1'b0; m_out = '0; m_rd = '0;
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      if (ev_oe_v[c]) m_oe = ev_oe[c];
      if (ev_oe_v[c] && ev_oe[c]) m_out = ev_out[c];
      if (ev_rd_v[c]) m_rd = ext_hist[ev_rd_src[c]];
      chk("rnd_ack",   32'(b.ack),   32'(ev_ack[c]));
      chk("rnd_rdata", 32'(b.rdata), 32'(m_rd));
      chk("rnd_busy",  32'(b.busy),  32'(ev_busy[c]));
      chk("rnd_oe",    32'(b.io_oe), 32'(m_oe));
      if (m_oe) chk("rnd_out", 32'(b.io_out), 32'(m_out));

      for (int i = 0; i < N; i++) begin
        if (ev_ack[c][i]) b.req[i] = 1'b0;
        else if (!b.req[i] && c < NC - 12 && $urandom_range(0, 2) == 0) begin
          b.req[i] = 1'b1;
          b.we[i]  = 1'($urandom_range(0, 1));
          b.wdata[i*W +: W] = W'($urandom);
        end
      end
      ext1 = W'($urandom);
      ext_hist[c] = ext1;

      if (c >= m_free && b.req != '0) begin
        idx = -1;
        for (int k = 1; k <= N; k++)
          if (idx < 0 && b.req[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
        turn = (b.we[idx] != m_dir) ? TC : 0;
        x = c + 1 + turn;
        for (int j = c + 1; j <= x; j++) ev_busy[j] = 1'b1;
        ev_ack[x+1][idx] = 1'b1;
        if (b.we[idx]) begin
          ev_oe_v[x] = 1'b1; ev_oe[x] = 1'b1; ev_out[x] = b.wdata[idx*W +: W];
          if (!PARK) begin ev_oe_v[x+1] = 1'b1; ev_oe[x+1] = 1'b0; end
        end else begin
          ev_rd_v[x+1] = 1'b1; ev_rd_src[x+1] = x;
          ev_oe_v[c+1] = 1'b1; ev_oe[c+1] = 1'b0;
        end
        m_ptr = idx; m_dir = b.we[idx]; m_free = x + 2;
      end
    end
    b.req = '0;

    // TURN_CYC=0 instance: drive then sample, no dead cycle.
    @(negedge clk);
    b2.req = 2'b01; b2.we = 2'b01; b2.wdata = 4'b0001; b2.io_in = 2'b11;
    @(negedge clk);
    chk("tc0_drv_oe",  32'(b2.io_oe),  32'd1);
    chk("tc0_drv_out", 32'(b2.io_out), 32'd1);
    chk("tc0_drv_ack_early", 32'(b2.ack), 32'd0);
    @(negedge clk);
    chk("tc0_drv_ack", 32'(b2.ack), 32'd1);
    b2.req = '0;
    @(negedge clk);
    b2.req = 2'b10; b2.we = 2'b00; b2.io_in = 2'b10;
    @(negedge clk);
    chk("tc0_smp_oe",   32'(b2.io_oe), 32'd0);
    chk("tc0_smp_busy", 32'(b2.busy),  32'd1);
    chk("tc0_smp_ack_early", 32'(b2.ack), 32'd0);
    @(negedge clk);
    chk("tc0_smp_ack",   32'(b2.ack),   32'd2);
    chk("tc0_smp_rdata", 32'(b2.rdata), 32'd2);
    b2.req = '0;

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
